// File: rtl/thumb_pkg.sv
// rtl/thumb_pkg.sv - shared encodings for the Thumb multi-register sequencer
//
// Contents: command op encodings, architectural register indices,
// sequencer state enum, and the mask-bit to register translation.

package thumb_pkg;

    localparam logic [1:0] OP_STM  = 2'b00;
    localparam logic [1:0] OP_LDM  = 2'b01;
    localparam logic [1:0] OP_PUSH = 2'b10;
    localparam logic [1:0] OP_POP  = 2'b11;

    localparam logic [3:0] REG_SP = 4'hd;
    localparam logic [3:0] REG_LR = 4'he;
    localparam logic [3:0] REG_PC = 4'hf;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_FINISH = 2'd2
    } state_e;

    // Mask bit 8 stands for LR on PUSH and PC on POP; bits 0-7 are r0-r7.
    function automatic logic [3:0] mask_bit_to_reg(input logic [3:0] idx,
                                                   input logic [1:0] op);
        logic [3:0] r;
        if (idx == 4'd8) begin
            r = (op == OP_PUSH) ? REG_LR : REG_PC;
        end else begin
            r = idx;
        end
        return r;
    endfunction

endpackage

// File: rtl/thumb_reglist_scan.sv
// rtl/thumb_reglist_scan.sv - combinational scan of a 9-bit register mask
//
// Ports:
//   mask       in  9  working register mask (bit 8 = LR/PC slot)
//   count      out 4  number of set bits, 0..9
//   lowest_idx out 4  index of the lowest set bit (0 when mask is empty)
//   single     out 1  exactly one bit set

module thumb_reglist_scan (
    input  logic [8:0] mask,
    output logic [3:0] count,
    output logic [3:0] lowest_idx,
    output logic       single
);

    always_comb begin
        count      = '0;
        lowest_idx = '0;
        // Scan downwards so the last hit wins, leaving the lowest set bit.
        for (int i = 8; i >= 0; i--) begin
            if (mask[i]) begin
                lowest_idx = 4'(i);
            end
        end
        for (int i = 0; i < 9; i++) begin
            count = count + {3'b000, mask[i]};
        end
        single = (count == 4'd1);
    end

endmodule

// File: rtl/thumb_multireg_sequencer.sv
// rtl/thumb_multireg_sequencer.sv - splits STM/LDM/PUSH/POP into per-register LSU micro-ops
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cmd_valid/cmd_ready           decode-stage command handshake (ready only in IDLE)
//   cmd_op/rn/list/rbit/base      decoded command fields
//   flush                         synchronous abort, highest priority
//   uop_valid/uop_ready           LSU micro-op handshake
//   uop_load/reg/addr/last        micro-op payload
//   wb_valid/wb_reg/wb_value      one-cycle base register writeback
//   done                          one-cycle completion pulse
// All outputs are registered.

module thumb_multireg_sequencer
    import thumb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int STEP   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [3:0]        cmd_rn,
    input  logic [7:0]        cmd_list,
    input  logic              cmd_rbit,
    input  logic [ADDR_W-1:0] cmd_base,
    input  logic              flush,
    output logic              uop_valid,
    input  logic              uop_ready,
    output logic              uop_load,
    output logic [3:0]        uop_reg,
    output logic [ADDR_W-1:0] uop_addr,
    output logic              uop_last,
    output logic              wb_valid,
    output logic [3:0]        wb_reg,
    output logic [ADDR_W-1:0] wb_value,
    output logic              done
);

    // Control state
    state_e            state_q, state_d;
    logic [8:0]        mask_q, mask_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] final_q, final_d;
    logic [1:0]        op_q, op_d;
    logic [3:0]        rn_q, rn_d;
    logic              wb_en_q, wb_en_d;

    // Registered outputs
    logic              cmd_ready_q, cmd_ready_d;
    logic              uop_valid_q, uop_valid_d;
    logic              uop_load_q, uop_load_d;
    logic [3:0]        uop_reg_q, uop_reg_d;
    logic [ADDR_W-1:0] uop_addr_q, uop_addr_d;
    logic              uop_last_q, uop_last_d;
    logic              wb_valid_q, wb_valid_d;
    logic [3:0]        wb_reg_q, wb_reg_d;
    logic [ADDR_W-1:0] wb_value_q, wb_value_d;
    logic              done_q, done_d;

    // Incoming command decode
    logic              cmd_has_rbit;
    logic [8:0]        cmd_mask;
    logic [3:0]        cmd_count;
    logic [3:0]        cmd_lowest_unused;
    logic              cmd_single_unused;
    logic [ADDR_W-1:0] cmd_span;
    logic [ADDR_W-1:0] cmd_start;
    logic [ADDR_W-1:0] cmd_final;
    logic              cmd_rn_in_list;
    logic              cmd_wb_en;

    // Scan of the mask that will be live next cycle, feeding the registered uop fields
    logic [3:0]        next_count_unused;
    logic [3:0]        next_lowest;
    logic              next_single;

    logic              uop_fire;

    assign cmd_has_rbit = (cmd_op == OP_PUSH) || (cmd_op == OP_POP);
    assign cmd_mask     = {cmd_rbit & cmd_has_rbit, cmd_list};

    thumb_reglist_scan u_scan_cmd (
        .mask       (cmd_mask),
        .count      (cmd_count),
        .lowest_idx (cmd_lowest_unused),
        .single     (cmd_single_unused)
    );

    thumb_reglist_scan u_scan_next (
        .mask       (mask_d),
        .count      (next_count_unused),
        .lowest_idx (next_lowest),
        .single     (next_single)
    );

    assign cmd_span  = ADDR_W'(STEP) * ADDR_W'(cmd_count);
    // PUSH is a full-descending store: it starts below the base and the
    // new SP is that start address; everything else walks upward from base.
    assign cmd_start = (cmd_op == OP_PUSH) ? (cmd_base - cmd_span) : cmd_base;
    assign cmd_final = (cmd_op == OP_PUSH) ? (cmd_base - cmd_span) : (cmd_base + cmd_span);

    // An LDM that loads its own base keeps the loaded value, so no writeback.
    assign cmd_rn_in_list = !cmd_rn[3] && cmd_list[cmd_rn[2:0]];
    assign cmd_wb_en      = (cmd_count != 4'd0) && !((cmd_op == OP_LDM) && cmd_rn_in_list);

    assign uop_fire = uop_valid_q && uop_ready;

    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        addr_d      = addr_q;
        final_d     = final_q;
        op_d        = op_q;
        rn_d        = rn_q;
        wb_en_d     = wb_en_q;
        uop_valid_d = 1'b0;
        uop_load_d  = uop_load_q;
        uop_reg_d   = uop_reg_q;
        uop_addr_d  = uop_addr_q;
        uop_last_d  = uop_last_q;
        wb_valid_d  = 1'b0;
        wb_reg_d    = wb_reg_q;
        wb_value_d  = wb_value_q;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    mask_d  = cmd_mask;
                    addr_d  = cmd_start;
                    final_d = cmd_final;
                    op_d    = cmd_op;
                    rn_d    = cmd_rn;
                    wb_en_d = cmd_wb_en;
                    if (cmd_count == 4'd0) begin
                        state_d = ST_FINISH;
                        done_d  = 1'b1;
                    end else begin
                        state_d     = ST_ISSUE;
                        uop_valid_d = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                if (uop_fire) begin
                    mask_d = mask_q & (mask_q - 9'd1);
                    addr_d = addr_q + ADDR_W'(STEP);
                    if (uop_last_q) begin
                        state_d    = ST_FINISH;
                        done_d     = 1'b1;
                        wb_valid_d = wb_en_q;
                        wb_reg_d   = rn_q;
                        wb_value_d = final_q;
                    end else begin
                        uop_valid_d = 1'b1;
                    end
                end else begin
                    uop_valid_d = 1'b1;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Payload only changes when the next cycle carries a micro-op, so a
        // stalled micro-op recomputes to identical values.
        if (uop_valid_d) begin
            uop_load_d = (op_d == OP_LDM) || (op_d == OP_POP);
            uop_reg_d  = mask_bit_to_reg(next_lowest, op_d);
            uop_addr_d = addr_d;
            uop_last_d = next_single;
        end

        if (flush) begin
            state_d     = ST_IDLE;
            uop_valid_d = 1'b0;
            wb_valid_d  = 1'b0;
            done_d      = 1'b0;
        end

        cmd_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mask_q      <= '0;
            addr_q      <= '0;
            final_q     <= '0;
            op_q        <= OP_STM;
            rn_q        <= '0;
            wb_en_q     <= 1'b0;
            cmd_ready_q <= 1'b1;
            uop_valid_q <= 1'b0;
            uop_load_q  <= 1'b0;
            uop_reg_q   <= '0;
            uop_addr_q  <= '0;
            uop_last_q  <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_reg_q    <= '0;
            wb_value_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            addr_q      <= addr_d;
            final_q     <= final_d;
            op_q        <= op_d;
            rn_q        <= rn_d;
            wb_en_q     <= wb_en_d;
            cmd_ready_q <= cmd_ready_d;
            uop_valid_q <= uop_valid_d;
            uop_load_q  <= uop_load_d;
            uop_reg_q   <= uop_reg_d;
            uop_addr_q  <= uop_addr_d;
            uop_last_q  <= uop_last_d;
            wb_valid_q  <= wb_valid_d;
            wb_reg_q    <= wb_reg_d;
            wb_value_q  <= wb_value_d;
            done_q      <= done_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign uop_valid = uop_valid_q;
    assign uop_load  = uop_load_q;
    assign uop_reg   = uop_reg_q;
    assign uop_addr  = uop_addr_q;
    assign uop_last  = uop_last_q;
    assign wb_valid  = wb_valid_q;
    assign wb_reg    = wb_reg_q;
    assign wb_value  = wb_value_q;
    assign done      = done_q;

endmodule

// File: tb/tb_thumb_multireg_sequencer.sv
// tb/tb_thumb_multireg_sequencer.sv - self-checking bench for thumb_multireg_sequencer

module tb_thumb_multireg_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [3:0]  cmd_rn;
    logic [7:0]  cmd_list;
    logic        cmd_rbit;
    logic [31:0] cmd_base;
    logic        flush;
    logic        uop_valid;
    logic        uop_ready;
    logic        uop_load;
    logic [3:0]  uop_reg;
    logic [31:0] uop_addr;
    logic        uop_last;
    logic        wb_valid;
    logic [3:0]  wb_reg;
    logic [31:0] wb_value;
    logic        done;

    thumb_multireg_sequencer #(.ADDR_W(32), .STEP(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_rn(cmd_rn), .cmd_list(cmd_list), .cmd_rbit(cmd_rbit), .cmd_base(cmd_base),
        .flush(flush),
        .uop_valid(uop_valid), .uop_ready(uop_ready), .uop_load(uop_load),
        .uop_reg(uop_reg), .uop_addr(uop_addr), .uop_last(uop_last),
        .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_value(wb_value), .done(done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: the list of transfers an instruction makes, from the ISA rules.
    logic [3:0]  exp_reg[$];
    logic [31:0] exp_addr[$];
    logic        exp_load;
    logic        exp_wb;
    logic [31:0] exp_wb_value;

    task automatic build_model(input logic [1:0] op, input logic [3:0] rn, input logic [7:0] list,
                               input logic rbit, input logic [31:0] base);
        int          n;
        logic [31:0] start;
        exp_reg.delete();
        exp_addr.delete();
        for (int r = 0; r < 8; r++) begin
            if (list[r]) exp_reg.push_back(4'(r));
        end
        if (rbit && op == 2'b10) exp_reg.push_back(4'd14);
        if (rbit && op == 2'b11) exp_reg.push_back(4'd15);
        n = exp_reg.size();
        start = (op == 2'b10) ? base - 32'(4 * n) : base;
        for (int k = 0; k < n; k++) exp_addr.push_back(start + 32'(4 * k));
        exp_load     = (op == 2'b01) || (op == 2'b11);
        exp_wb_value = (op == 2'b10) ? start : base + 32'(4 * n);
        exp_wb       = (n != 0) && !(op == 2'b01 && rn < 4'd8 && list[rn[2:0]]);
    endtask

    // abort_kind: 0 none, 1 flush, 2 reset, applied while micro-op abort_at is valid.
    // ready_mode: 0 always ready, 1 random. hold_first: cycles ready is held low on the first uop.
    task automatic run_cmd(input logic [1:0] op, input logic [3:0] rn, input logic [7:0] list,
                           input logic rbit, input logic [31:0] base,
                           input int abort_at, input int abort_kind,
                           input int ready_mode, input int hold_first);
        int          n;
        int          cyc;
        int          idx;
        int          held;
        bit          prev_hold;
        logic [37:0] saved;
        logic        late_evt;
        build_model(op, rn, list, rbit, base);
        n = exp_reg.size();
        check_eq("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_rn    = rn;
        cmd_list  = list;
        cmd_rbit  = rbit;
        cmd_base  = base;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cyc       = 1;
        idx       = 0;
        held      = 0;
        prev_hold = 1'b0;
        saved     = '0;
        while (1) begin
            if (cyc > 200) begin
                check_eq("timeout", 32'd0, 32'd1);
                break;
            end
            if (uop_valid && wb_valid) check_eq("uop_wb_overlap", 32'd1, 32'd0);
            if (cyc == 1) check_eq("first_uop_latency", 32'(uop_valid), 32'(n != 0));
            if (done) begin
                check_eq("uops_issued", 32'(idx), 32'(n));
                check_eq("wb_valid", 32'(wb_valid), 32'(exp_wb));
                if (exp_wb) begin
                    check_eq("wb_reg", 32'(wb_reg), 32'(rn));
                    check_eq("wb_value", wb_value, exp_wb_value);
                end
                if (ready_mode == 0 && hold_first == 0) check_eq("cmd_latency", 32'(cyc), 32'(n + 1));
                @(negedge clk);
                check_eq("ready_after_done", 32'(cmd_ready), 32'd1);
                check_eq("done_one_cycle", 32'(done), 32'd0);
                break;
            end
            if (!uop_valid) begin
                check_eq("uop_gap", 32'd0, 32'd1);
                break;
            end
            if (prev_hold) check_eq("uop_stable", 32'({uop_load, uop_reg, uop_last} ^ saved[5:0]) |
                                                  (uop_addr ^ saved[37:6]), 32'd0);
            if (idx >= n) begin
                check_eq("extra_uop", 32'(idx), 32'(n));
                break;
            end
            if (abort_kind != 0 && idx == abort_at) begin
                if (abort_kind == 1) flush = 1'b1;
                else rst = 1'b1;
                uop_ready = 1'($urandom_range(0, 1));
                @(negedge clk);
                flush     = 1'b0;
                rst       = 1'b0;
                uop_ready = 1'b0;
                check_eq("abort_uop_valid", 32'(uop_valid), 32'd0);
                check_eq("abort_cmd_ready", 32'(cmd_ready), 32'd1);
                if (abort_kind == 2) begin
                    check_eq("rst_uop_fields", 32'({uop_load, uop_reg, uop_last}), 32'd0);
                    check_eq("rst_uop_addr", uop_addr, 32'd0);
                    check_eq("rst_wb_fields", 32'(wb_reg) | wb_value, 32'd0);
                end
                late_evt = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    late_evt = late_evt | done | wb_valid | uop_valid;
                    @(negedge clk);
                end
                check_eq("abort_no_done_wb", 32'(late_evt), 32'd0);
                return;
            end
            if (idx == 0 && held < hold_first) begin
                uop_ready = 1'b0;
                held++;
            end else if (ready_mode == 1) begin
                uop_ready = ($urandom_range(0, 3) != 0);
            end else begin
                uop_ready = 1'b1;
            end
            if (uop_ready) begin
                check_eq("uop_load", 32'(uop_load), 32'(exp_load));
                check_eq("uop_reg", 32'(uop_reg), 32'(exp_reg[idx]));
                check_eq("uop_addr", uop_addr, exp_addr[idx]);
                check_eq("uop_last", 32'(uop_last), 32'(idx == n - 1));
                idx++;
                prev_hold = 1'b0;
            end else begin
                prev_hold = 1'b1;
                saved     = {uop_addr, uop_load, uop_reg, uop_last};
            end
            @(negedge clk);
            cyc++;
        end
        uop_ready = 1'b0;
    endtask

    initial begin
        logic [1:0]  r_op;
        logic [3:0]  r_rn;
        logic [7:0]  r_list;
        logic        r_rbit;
        logic [31:0] r_base;
        int          r_n;
        int          r_kind;
        logic        idle_evt;

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_rn    = 4'd0;
        cmd_list  = 8'd0;
        cmd_rbit  = 1'b0;
        cmd_base  = 32'd0;
        flush     = 1'b0;
        uop_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        check_eq("reset_uop", 32'({uop_valid, uop_load, uop_reg, uop_last}), 32'd0);
        check_eq("reset_uop_addr", uop_addr, 32'd0);
        check_eq("reset_wb", 32'({wb_valid, wb_reg, done}), 32'd0);
        check_eq("reset_wb_value", wb_value, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_cmd(2'b00, 4'd1, 8'b0000_0101, 1'b0, 32'h1000, 0, 0, 0, 0);   // STM r1!
        run_cmd(2'b10, 4'hd, 8'b0001_0000, 1'b1, 32'h2000, 0, 0, 0, 0);  // PUSH {r4,lr}
        run_cmd(2'b11, 4'hd, 8'b0000_0001, 1'b1, 32'h1FF8, 0, 0, 0, 3);  // POP {r0,pc}, stalled
        run_cmd(2'b01, 4'd2, 8'b0000_0110, 1'b0, 32'h3000, 0, 0, 0, 0);   // LDM r2! incl. r2
        run_cmd(2'b00, 4'd3, 8'b0000_0000, 1'b0, 32'h4000, 0, 0, 0, 0);   // empty STM
        run_cmd(2'b10, 4'hd, 8'hFF, 1'b1, 32'h2000, 3, 1, 0, 0);          // PUSH all, flush
        run_cmd(2'b00, 4'd5, 8'b1000_0001, 1'b0, 32'h5000, 0, 0, 0, 0);
        run_cmd(2'b10, 4'hd, 8'hFF, 1'b1, 32'h2000, 3, 2, 0, 0);          // PUSH all, reset
        run_cmd(2'b00, 4'd5, 8'b1000_0001, 1'b0, 32'h5000, 0, 0, 0, 0);
        run_cmd(2'b10, 4'hd, 8'b0000_0011, 1'b0, 32'h0000_0004, 0, 0, 0, 0); // wraps below 0

        // Flush in the same cycle as an offered command rejects it.
        cmd_valid = 1'b1;
        flush     = 1'b1;
        cmd_op    = 2'b00;
        cmd_list  = 8'h03;
        cmd_base  = 32'h6000;
        @(negedge clk);
        cmd_valid = 1'b0;
        flush     = 1'b0;
        idle_evt  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            idle_evt = idle_evt | uop_valid | done | wb_valid | !cmd_ready;
            @(negedge clk);
        end
        check_eq("flush_rejects_cmd", 32'(idle_evt), 32'd0);

        for (int t = 0; t < 80; t++) begin
            r_op   = 2'($urandom_range(0, 3));
            r_rn   = r_op[1] ? 4'hd : 4'($urandom_range(0, 15));
            r_list = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
            r_rbit = 1'($urandom_range(0, 1));
            r_base = ($urandom_range(0, 4) == 0) ? 32'($urandom_range(0, 8) * 4) : ($urandom & 32'hFFFF_FFFC);
            r_n    = $countones(r_list) + ((r_rbit && r_op[1]) ? 1 : 0);
            r_kind = ($urandom_range(0, 7) == 0 && r_n > 0) ? int'($urandom_range(1, 2)) : 0;
            run_cmd(r_op, r_rn, r_list, r_rbit, r_base,
                    (r_n > 0) ? int'($urandom_range(0, r_n - 1)) : 0, r_kind,
                    int'($urandom_range(0, 1)), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
